// File: rtl/stream_prefetcher.sv
// stream_prefetcher
// -----------------
// Next-line prefetcher sitting between the Dcache read port and the AXI read
// bridge. A cached miss becomes one wide AXI read returning FETCH_LINES
// consecutive lines. Line 0 goes straight back to the cache; lines
// 1..FETCH_LINES-1 are parked in an ENTRIES-deep buffer with FIFO
// replacement. A later cached read that finds its line in the buffer is
// answered locally one cycle after acceptance, and the entry is released
// because the line now lives in the Dcache.
//
// Handshake: a request transfers on a cycle where req and rdy are both high
// (cache_rd_req/cache_rd_rdy on the cache side, axi_rd_req/axi_rd_rdy on the
// bridge side); neither rdy waits on anything later than the same cycle's
// req. Returns are single-cycle valid pulses with no back-pressure.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   pf_en             prefetch enable; 0 = pass-through, buffer flushed
//   cache_rd_*        Dcache read request (type 1 = cached line read)
//   cache_ret_*       return to the Dcache
//   cache_wr_*        Dcache write to memory, snooped to drop stale lines
//   axi_rd_*          read request to the AXI bridge (type/addr pass through)
//   axi_ret_*         single-beat wide return; slice k = miss line + k
//   hit_cnt           buffer hits since reset, wraps modulo 2^32
//   dbg_state         current FSM state
module stream_prefetcher #(
    parameter int ADDR_W      = 32,
    parameter int LINE_BYTES  = 16,
    parameter int FETCH_LINES = 2,
    parameter int ENTRIES     = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 pf_en,
    input  logic                                 cache_rd_req,
    input  logic                                 cache_rd_type,
    input  logic [ADDR_W-1:0]                    cache_rd_addr,
    output logic                                 cache_rd_rdy,
    output logic                                 cache_ret_valid,
    output logic [8*LINE_BYTES-1:0]              cache_ret_data,
    input  logic                                 cache_wr_req,
    input  logic [ADDR_W-1:0]                    cache_wr_addr,
    output logic                                 axi_rd_req,
    output logic                                 axi_rd_type,
    output logic [ADDR_W-1:0]                    axi_rd_addr,
    input  logic                                 axi_rd_rdy,
    input  logic                                 axi_ret_valid,
    input  logic [8*LINE_BYTES*FETCH_LINES-1:0]  axi_ret_data,
    output logic [31:0]                          hit_cnt,
    output logic [1:0]                           dbg_state
);

    localparam int LW    = 8 * LINE_BYTES;
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int TAG_W = ADDR_W - OFF_W;
    localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MISS_C = 2'd1,
        S_MISS_U = 2'd2,
        S_HIT    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [ENTRIES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q  [ENTRIES];
    logic [TAG_W-1:0]     tag_d  [ENTRIES];
    logic [LW-1:0]        data_q [ENTRIES];
    logic [LW-1:0]        data_d [ENTRIES];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [TAG_W-1:0]     miss_tag_q, miss_tag_d;
    logic [LW-1:0]        hit_data_q, hit_data_d;
    logic [31:0]          hit_cnt_q, hit_cnt_d;

    logic [TAG_W-1:0]     rd_tag;
    logic [TAG_W-1:0]     wr_tag;
    logic                 hit_found;
    logic [PTR_W-1:0]     hit_idx;
    logic                 hit;
    logic                 fill;
    logic [TAG_W-1:0]     fill_tag;
    logic [PTR_W-1:0]     fill_slot;
    logic                 unused_bits;

    assign rd_tag = cache_rd_addr[ADDR_W-1:OFF_W];
    assign wr_tag = cache_wr_addr[ADDR_W-1:OFF_W];
    assign unused_bits = ^{cache_rd_addr[OFF_W-1:0], cache_wr_addr[OFF_W-1:0]};

    // Buffer lookup. An entry being snooped this cycle is already stale, so
    // it must not produce a hit. Fills never leave duplicate tags, so at most
    // one entry matches.
    always_comb begin
        hit_found = 1'b0;
        hit_idx   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!hit_found && valid_q[i] && (tag_q[i] == rd_tag) &&
                !(cache_wr_req && (tag_q[i] == wr_tag))) begin
                hit_found = 1'b1;
                hit_idx   = PTR_W'(i);
            end
        end
    end

    assign hit = (state_q == S_IDLE) && cache_rd_req && cache_rd_type &&
                 pf_en && hit_found;

    assign axi_rd_req   = (state_q == S_IDLE) && cache_rd_req && !hit;
    assign axi_rd_type  = cache_rd_type;
    assign axi_rd_addr  = cache_rd_addr;
    assign cache_rd_rdy = (state_q == S_IDLE) && (hit || axi_rd_rdy);
    assign fill         = (state_q == S_MISS_C) && axi_ret_valid && pf_en;
    assign hit_cnt      = hit_cnt_q;
    assign dbg_state    = state_q;

    // Next-state and return path.
    always_comb begin
        state_d         = state_q;
        miss_tag_d      = miss_tag_q;
        hit_data_d      = hit_data_q;
        hit_cnt_d       = hit_cnt_q;
        cache_ret_valid = 1'b0;
        cache_ret_data  = '0;
        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    state_d    = S_HIT;
                    hit_data_d = data_q[hit_idx];
                    hit_cnt_d  = hit_cnt_q + 32'd1;
                end else if (axi_rd_req && axi_rd_rdy) begin
                    state_d    = cache_rd_type ? S_MISS_C : S_MISS_U;
                    miss_tag_d = cache_rd_type ? rd_tag : miss_tag_q;
                end
            end
            S_MISS_C, S_MISS_U: begin
                cache_ret_valid = axi_ret_valid;
                cache_ret_data  = axi_ret_data[LW-1:0];
                if (axi_ret_valid) begin
                    state_d = S_IDLE;
                end
            end
            S_HIT: begin
                cache_ret_valid = 1'b1;
                cache_ret_data  = hit_data_q;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Buffer update. Order matters: hit release, then fill (dedupe before
    // each write), then snoop on the resulting tags so a snooped line being
    // filled lands invalid, then the global flush when prefetch is off.
    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        data_d    = data_q;
        wr_ptr_d  = wr_ptr_q;
        fill_tag  = '0;
        fill_slot = '0;

        if (hit) begin
            valid_d[hit_idx] = 1'b0;
        end

        if (fill) begin
            for (int k = 1; k < FETCH_LINES; k++) begin
                // Adding k lines to the address is adding k to the tag; the
                // tag width wraps exactly where the address would.
                fill_tag  = miss_tag_q + TAG_W'(k);
                fill_slot = PTR_W'((int'(wr_ptr_q) + k - 1) % ENTRIES);
                for (int i = 0; i < ENTRIES; i++) begin
                    if (tag_d[i] == fill_tag) begin
                        valid_d[i] = 1'b0;
                    end
                end
                tag_d[fill_slot]   = fill_tag;
                data_d[fill_slot]  = axi_ret_data[k*LW +: LW];
                valid_d[fill_slot] = 1'b1;
            end
            wr_ptr_d = PTR_W'((int'(wr_ptr_q) + FETCH_LINES - 1) % ENTRIES);
        end

        if (cache_wr_req) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (tag_d[i] == wr_tag) begin
                    valid_d[i] = 1'b0;
                end
            end
        end

        if (!pf_en) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            valid_q    <= '0;
            wr_ptr_q   <= '0;
            miss_tag_q <= '0;
            hit_data_q <= '0;
            hit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            wr_ptr_q   <= wr_ptr_d;
            miss_tag_q <= miss_tag_d;
            hit_data_q <= hit_data_d;
            hit_cnt_q  <= hit_cnt_d;
        end
    end

    // Tag and data storage are qualified by valid_q and need no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_stream_prefetcher.sv
// Bench for stream_prefetcher. Two instances run side by side:
// index 0 with FETCH_LINES=2, index 1 with FETCH_LINES=4 (both ENTRIES=4).
// Inputs are driven at the falling edge, outputs sampled 1 time unit later.
module tb_stream_prefetcher;

    localparam int LW = 128;
    localparam int DW = 512;
    localparam int NE = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          pf_en       [2];
    logic          rd_req      [2];
    logic          rd_type     [2];
    logic [31:0]   rd_addr     [2];
    logic          wr_req      [2];
    logic [31:0]   wr_addr     [2];
    logic          axi_rdy     [2];
    logic          ret_v_in    [2];
    logic [DW-1:0] ret_data_in [2];
    logic          rd_rdy      [2];
    logic          ret_valid   [2];
    logic [LW-1:0] ret_data    [2];
    logic          axi_req     [2];
    logic          axi_type    [2];
    logic [31:0]   axi_addr    [2];
    logic [31:0]   hit_cnt     [2];
    logic [1:0]    dbg         [2];

    stream_prefetcher #(.ADDR_W(32), .LINE_BYTES(16), .FETCH_LINES(2), .ENTRIES(NE)) u_dut0 (
        .clk(clk), .reset(reset), .pf_en(pf_en[0]),
        .cache_rd_req(rd_req[0]), .cache_rd_type(rd_type[0]), .cache_rd_addr(rd_addr[0]),
        .cache_rd_rdy(rd_rdy[0]), .cache_ret_valid(ret_valid[0]), .cache_ret_data(ret_data[0]),
        .cache_wr_req(wr_req[0]), .cache_wr_addr(wr_addr[0]),
        .axi_rd_req(axi_req[0]), .axi_rd_type(axi_type[0]), .axi_rd_addr(axi_addr[0]),
        .axi_rd_rdy(axi_rdy[0]), .axi_ret_valid(ret_v_in[0]), .axi_ret_data(ret_data_in[0][255:0]),
        .hit_cnt(hit_cnt[0]), .dbg_state(dbg[0])
    );

    stream_prefetcher #(.ADDR_W(32), .LINE_BYTES(16), .FETCH_LINES(4), .ENTRIES(NE)) u_dut1 (
        .clk(clk), .reset(reset), .pf_en(pf_en[1]),
        .cache_rd_req(rd_req[1]), .cache_rd_type(rd_type[1]), .cache_rd_addr(rd_addr[1]),
        .cache_rd_rdy(rd_rdy[1]), .cache_ret_valid(ret_valid[1]), .cache_ret_data(ret_data[1]),
        .cache_wr_req(wr_req[1]), .cache_wr_addr(wr_addr[1]),
        .axi_rd_req(axi_req[1]), .axi_rd_type(axi_type[1]), .axi_rd_addr(axi_addr[1]),
        .axi_rd_rdy(axi_rdy[1]), .axi_ret_valid(ret_v_in[1]), .axi_ret_data(ret_data_in[1]),
        .hit_cnt(hit_cnt[1]), .dbg_state(dbg[1])
    );

    int tests = 0;
    int fails = 0;

    // Reference model: a bag of buffered lines per instance, addressed by
    // slot, with a FIFO pointer.
    logic          m_valid [2][NE];
    logic [27:0]   m_tag   [2][NE];
    logic [LW-1:0] m_data  [2][NE];
    int            m_ptr   [2];
    logic [31:0]   m_cnt   [2];
    logic [LW-1:0] exp_q[$];

    function automatic int fl_of(int d);
        return (d == 0) ? 2 : 4;
    endfunction

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NE; i++) m_valid[d][i] = 1'b0;
            m_ptr[d] = 0;
            m_cnt[d] = 32'd0;
        end
    endtask

    task automatic m_clear(int d);
        for (int i = 0; i < NE; i++) m_valid[d][i] = 1'b0;
    endtask

    function automatic int m_find(int d, logic [31:0] a);
        for (int i = 0; i < NE; i++)
            if (m_valid[d][i] && m_tag[d][i] == a[31:4]) return i;
        return -1;
    endfunction

    task automatic m_snoop(int d, logic [31:0] a);
        for (int i = 0; i < NE; i++)
            if (m_tag[d][i] == a[31:4]) m_valid[d][i] = 1'b0;
    endtask

    task automatic m_fill(int d, logic [31:0] miss, logic [DW-1:0] line);
        logic [31:0] a;
        int slot;
        for (int k = 1; k < fl_of(d); k++) begin
            a = miss + 32'(k * 16);
            for (int i = 0; i < NE; i++)
                if (m_valid[d][i] && m_tag[d][i] == a[31:4]) m_valid[d][i] = 1'b0;
            slot = (m_ptr[d] + k - 1) % NE;
            m_tag[d][slot]   = a[31:4];
            m_data[d][slot]  = line[k*LW +: LW];
            m_valid[d][slot] = 1'b1;
        end
        m_ptr[d] = (m_ptr[d] + fl_of(d) - 1) % NE;
    endtask

    task automatic idle_inputs(int d);
        rd_req[d]   = 1'b0;
        wr_req[d]   = 1'b0;
        axi_rdy[d]  = 1'b0;
        ret_v_in[d] = 1'b0;
    endtask

    // One cached/uncached read on instance d, acting as the AXI bridge on a
    // miss. ls_* snoops in the lookup cycle, fs_* snoops in the return cycle.
    task automatic do_read(int d, logic [31:0] addr, logic typ,
                           logic ls_en, logic [31:0] ls_addr,
                           logic fs_en, logic [31:0] fs_addr);
        int idx;
        int w;
        logic [DW-1:0] line;
        if (ls_en) m_snoop(d, ls_addr);
        idx = (typ && pf_en[d]) ? m_find(d, addr) : -1;
        rd_req[d]  = 1'b1;
        rd_type[d] = typ;
        rd_addr[d] = addr;
        wr_req[d]  = ls_en;
        wr_addr[d] = ls_addr;
        if (idx >= 0) begin
            axi_rdy[d] = 1'($urandom_range(0, 1));
            #1;
            chk("hit_rd_rdy", rd_rdy[d], 1'b1);
            chk("hit_no_axi_req", axi_req[d], 1'b0);
            exp_q.push_back(m_data[d][idx]);
            m_valid[d][idx] = 1'b0;
            m_cnt[d] = m_cnt[d] + 32'd1;
            @(posedge clk);
            @(negedge clk);
            idle_inputs(d);
            #1;
            chk("hit_ret_valid", ret_valid[d], 1'b1);
            chk("hit_ret_data", ret_data[d], exp_q.pop_front());
            chk("hit_cnt", hit_cnt[d], m_cnt[d]);
            chk("hit_busy_rdy", rd_rdy[d], 1'b0);
            @(posedge clk);
            @(negedge clk);
        end else begin
            w = $urandom_range(0, 2);
            axi_rdy[d] = 1'b0;
            for (int i = 0; i < w; i++) begin
                #1;
                chk("miss_wait_req", axi_req[d], 1'b1);
                chk("miss_wait_rdy", rd_rdy[d], 1'b0);
                @(posedge clk);
                @(negedge clk);
                wr_req[d] = 1'b0;
            end
            axi_rdy[d] = 1'b1;
            #1;
            chk("miss_axi_req", axi_req[d], 1'b1);
            chk("miss_rd_rdy", rd_rdy[d], 1'b1);
            chk("miss_axi_type", axi_type[d], typ);
            chk("miss_axi_addr", axi_addr[d], addr);
            @(posedge clk);
            @(negedge clk);
            idle_inputs(d);
            w = $urandom_range(0, 2);
            for (int i = 0; i < w; i++) begin
                #1;
                chk("miss_pending_valid", ret_valid[d], 1'b0);
                chk("miss_pending_rdy", rd_rdy[d], 1'b0);
                @(posedge clk);
                @(negedge clk);
            end
            for (int i = 0; i < DW / 32; i++) line[i*32 +: 32] = $urandom();
            ret_v_in[d]    = 1'b1;
            ret_data_in[d] = line;
            wr_req[d]      = fs_en;
            wr_addr[d]     = fs_addr;
            exp_q.push_back(line[LW-1:0]);
            #1;
            chk("miss_ret_valid", ret_valid[d], 1'b1);
            chk("miss_ret_data", ret_data[d], exp_q.pop_front());
            @(posedge clk);
            if (typ && pf_en[d]) m_fill(d, addr, line);
            if (fs_en) m_snoop(d, fs_addr);
            @(negedge clk);
            idle_inputs(d);
        end
    endtask

    task automatic rd(int d, logic [31:0] addr);
        do_read(d, addr, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic do_snoop(int d, logic [31:0] a);
        wr_req[d]  = 1'b1;
        wr_addr[d] = a;
        @(posedge clk);
        m_snoop(d, a);
        @(negedge clk);
        wr_req[d] = 1'b0;
    endtask

    task automatic set_pf(int d, logic v);
        pf_en[d] = v;
        @(posedge clk);
        if (!v) m_clear(d);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r;
        logic [31:0] a;
        int          op;

        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            idle_inputs(d);
            pf_en[d]       = 1'b1;
            rd_type[d]     = 1'b1;
            rd_addr[d]     = 32'd0;
            wr_addr[d]     = 32'd0;
            ret_data_in[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_reset();

        // Reset state and pass-through of the request handshake.
        for (int d = 0; d < 2; d++) begin
            #1;
            chk("rst_ret_valid", ret_valid[d], 1'b0);
            chk("rst_hit_cnt", hit_cnt[d], 32'd0);
            chk("rst_idle_axi_req", axi_req[d], 1'b0);
            r = 1'($urandom_range(0, 1));
            rd_req[d]  = 1'b1;
            rd_addr[d] = 32'h0000_1000;
            axi_rdy[d] = r;
            #1;
            chk("rst_axi_req_follows", axi_req[d], 1'b1);
            chk("rst_rdy_follows", rd_rdy[d], r);
            idle_inputs(d);
            @(negedge clk);
        end

        // Next-line hit and consumption (FETCH_LINES=2).
        rd(0, 32'h0000_1000);
        rd(0, 32'h0000_1010);
        rd(0, 32'h0000_1010);

        // Snoop between fill and read; snoop in the lookup cycle.
        rd(0, 32'h0000_5000);
        do_snoop(0, 32'h0000_5014);
        rd(0, 32'h0000_5010);
        rd(0, 32'h0000_6000);
        do_read(0, 32'h0000_6010, 1'b1, 1'b1, 32'h0000_6018, 1'b0, 32'd0);

        // Snoop in the same cycle as the fill that would write that line.
        do_read(0, 32'h0000_9000, 1'b1, 1'b0, 32'd0, 1'b1, 32'h0000_9010);
        rd(0, 32'h0000_9010);

        // Uncached reads never fill.
        do_read(0, 32'h0000_7000, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        rd(0, 32'h0000_7010);

        // Prefetch disable flushes and suppresses fills; address wrap.
        rd(0, 32'h0000_8000);
        set_pf(0, 1'b0);
        rd(0, 32'h0000_8010);
        set_pf(0, 1'b1);
        rd(0, 32'h0000_8020);
        rd(0, 32'hFFFF_FFF0);
        rd(0, 32'h0000_0000);

        // FETCH_LINES=4: pointer wrap and replacement order.
        rd(1, 32'h0000_2000);
        rd(1, 32'h0000_3000);
        rd(1, 32'h0000_2010);
        rd(1, 32'h0000_2030);
        rd(1, 32'h0000_3030);
        rd(1, 32'hFFFF_FFE0);
        rd(1, 32'h0000_0000);

        // Reset while a cached miss is outstanding; the late return is ignored.
        rd(0, 32'h0000_A000);
        rd_req[0]  = 1'b1;
        rd_type[0] = 1'b1;
        rd_addr[0] = 32'h0000_B000;
        axi_rdy[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idle_inputs(0);
        #1;
        chk("missc_busy_rdy", rd_rdy[0], 1'b0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        ret_v_in[0] = 1'b1;
        for (int i = 0; i < DW / 32; i++) ret_data_in[0][i*32 +: 32] = $urandom();
        #1;
        chk("late_ret_ignored", ret_valid[0], 1'b0);
        chk("late_ret_hit_cnt", hit_cnt[0], 32'd0);
        @(posedge clk);
        @(negedge clk);
        idle_inputs(0);
        rd(0, 32'h0000_A010);
        rd(0, 32'h0000_B010);
        rd(0, 32'h0000_A010);

        // Randomized traffic over a small line pool so hits are frequent.
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 150; n++) begin
                op = $urandom_range(0, 99);
                a  = 32'h0000_4000 + 32'($urandom_range(0, 15) << 4) + 32'($urandom_range(0, 15));
                if (op < 3) begin
                    set_pf(d, 1'b0);
                end else if (op < 10) begin
                    set_pf(d, 1'b1);
                end else if (op < 18) begin
                    do_snoop(d, 32'h0000_4000 + 32'($urandom_range(0, 15) << 4));
                end else begin
                    do_read(d, a, (op < 90) ? 1'b1 : 1'b0,
                            ($urandom_range(0, 7) == 0),
                            32'h0000_4000 + 32'($urandom_range(0, 15) << 4),
                            ($urandom_range(0, 7) == 0),
                            32'h0000_4000 + 32'($urandom_range(0, 15) << 4));
                end
                #1;
                chk("rand_hit_cnt", hit_cnt[d], m_cnt[d]);
                chk("rand_idle_valid", ret_valid[d], 1'b0);
                @(negedge clk);
            end
            set_pf(d, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stream_prefetcher.md
Name: stream_prefetcher

Overview:
- Parametrised multi-entry next-line prefetcher between the Dcache read port and the AXI read bridge.
- Each cached miss is forwarded to AXI as a wide read returning FETCH_LINES consecutive lines.
- Line 0 goes to the cache. Lines 1..FETCH_LINES-1 are stored in an ENTRIES-deep FIFO-replaced buffer.
- Later cached reads that hit the buffer are served locally in one cycle.
- Adds three things over the single-line predecessor: write-snoop invalidation, a runtime enable, and a hit counter.

Parameters:
- ADDR_W, 32, address width.
- LINE_BYTES, 16, cache line size in bytes (power of 2). Line data width LW = 8*LINE_BYTES.
- FETCH_LINES, 2, lines per AXI cached read (2..8).
- ENTRIES, 4, buffer lines (power of 2, >= FETCH_LINES-1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pf_en  in  1  prefetch enable; 0 = pure pass-through and flush
- cache_rd_req  in  1  Dcache read request
- cache_rd_type  in  1  1 = cached line read, 0 = uncached
- cache_rd_addr  in  ADDR_W  request address
- cache_rd_rdy  out  1  request accepted
- cache_ret_valid  out  1  return data valid
- cache_ret_data  out  LW  returned line
- cache_wr_req  in  1  Dcache write to memory (snoop)
- cache_wr_addr  in  ADDR_W  snooped write address
- axi_rd_req  out  1  AXI bridge read request
- axi_rd_type  out  1  = cache_rd_type
- axi_rd_addr  out  ADDR_W  = cache_rd_addr
- axi_rd_rdy  in  1  bridge accepted request
- axi_ret_valid  in  1  return valid (single beat)
- axi_ret_data  in  LW*FETCH_LINES  slice k = line at miss address + k*LINE_BYTES
- hit_cnt  out  32  buffer hits since reset, wraps modulo 2^32

Behaviour:
- Line tag = addr[ADDR_W-1:log2(LINE_BYTES)]. Entry state: tag, valid, data. Replacement pointer wr_ptr wraps modulo ENTRIES.
- FSM states are IDLE, MISS_C (cached outstanding), MISS_U (uncached outstanding) and HIT. Only one request is outstanding at a time.
- hit = state==IDLE && cache_rd_req && cache_rd_type && pf_en && a valid entry tag matches && that entry is not invalidated by a snoop in the same cycle.
- cache_rd_rdy = (state==IDLE) && (hit || axi_rd_rdy). It is 0 in every other state.
- axi_rd_req = (state==IDLE) && cache_rd_req && !hit.
- IDLE -> HIT on hit:
  - Latch the entry data into a register.
  - Clear the entry's valid bit, since the line now lives in the Dcache.
  - Increment hit_cnt.
- IDLE -> MISS_C on axi_rd_req && axi_rd_rdy && type=1. Latch miss_addr.
- IDLE -> MISS_U on an accept with type=0.
- HIT: cache_ret_valid=1 and cache_ret_data=latched line. Returns to IDLE next cycle. Hit latency is one cycle from accept.
- MISS_C / MISS_U: cache_ret_valid=axi_ret_valid and cache_ret_data=axi_ret_data slice 0. Returns to IDLE on axi_ret_valid.
- Fill on axi_ret_valid in MISS_C with pf_en=1:
  - For k=1..FETCH_LINES-1, write slice k with tag(miss_addr + k*LINE_BYTES) into entry (wr_ptr+k-1) mod ENTRIES, and set it valid.
  - Before writing, clear any existing entry with the same tag so no duplicates exist.
  - wr_ptr advances by FETCH_LINES-1.
  - Address addition wraps modulo 2^ADDR_W.
- MISS_U returns never fill.
- Snoop: cache_wr_req with a tag matching a valid entry clears it at the clock edge.
  - Snoop of a line being filled in the same cycle: invalidation wins, and the line is written invalid.
- pf_en=0: no hits, no fills, all entries cleared every cycle. In-flight requests complete normally.
- Reset: state IDLE, all valid bits 0, wr_ptr 0, hit_cnt 0, latched data 0.
  - Outputs after reset: cache_ret_valid=0, axi_rd_req=cache_rd_req (combinational), cache_rd_rdy=axi_rd_rdy.
  - An AXI return arriving in IDLE (for example after reset mid-miss) is ignored: no cache_ret_valid, no fill.

Test Plan:
- FETCH_LINES=2, ENTRIES=4: cached miss 0x1000 -> axi_rd_req=1, ret slice 0 forwarded. Then read 0x1010 -> no AXI request, cache_rd_rdy=1, ret_valid next cycle with slice 1 data, hit_cnt=1. Repeat read 0x1010 -> misses (entry consumed).
- FETCH_LINES=4, ENTRIES=4: misses at 0x2000 then 0x3000 -> entries hold 0x3010/0x3020/0x3030 and 0x2030 (wr_ptr wrapped to 2). 0x2010 misses, 0x2030 hits.
- Miss 0x1000, then cache_wr_req 0x1014 -> read 0x1010 misses. Snoop in the same cycle as a hit lookup -> treated as miss and AXI request issued.
- Uncached read 0x1000 (type=0) -> forwarded, no fill. Read 0x1010 cached -> misses.
- pf_en=0 after a fill -> 0x1010 misses and buffer empty. Set pf_en=1 and miss at 0xFFFFFFF0 -> entry tag for 0x00000000 valid, and read 0x0 hits.
- reset asserted in MISS_C, then axi_ret_valid -> no cache_ret_valid, no entries valid, hit_cnt=0.
